// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - Byte write port (valid/ready) feeding the uart_tx FIFO.
interface uart_tx_if;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;

   modport master (
      output wr_data,
      output wr_valid,
      input  wr_ready
   );

   modport slave (
      input  wr_data,
      input  wr_valid,
      output wr_ready
   );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small input FIFO, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx #(
   parameter int CLK_FREQ_HZ     = 1000000,
   parameter int BAUD_RATE       = 100000,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   uart_tx_if.slave                 wr,
   output logic                     tx,
   output logic                     busy,
   output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
   localparam int PW           = FIFO_DEPTH_LOG2;
   localparam int CW           = FIFO_DEPTH_LOG2 + 1;
   localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
      end
      if (FIFO_DEPTH_LOG2 < 1 || FIFO_DEPTH_LOG2 > 6) begin : g_bad_depth
         $error("uart_tx: FIFO_DEPTH_LOG2 must be in 1..6");
      end
   endgenerate

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]       mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [7:0]       head;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             baud_end;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign push        = wr.wr_valid && !full;
   assign head        = mem[rd_ptr];
   assign wr.wr_ready = !full;
   assign fifo_count  = count_q;
   assign tx          = tx_q;
   assign busy        = (state_q != IDLE) || !empty;
   assign baud_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr.wr_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == IDLE || baud_end) ? '0 : cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               state_d = START;
               cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = ^head;
`endif
            end
         end
         START: begin
            if (baud_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // Popping here chains frames with no idle gap between stop and start.
            if (baud_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = START;
`ifdef UART_TX_PARITY_EN
                  par_d   = ^head;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule
